// File: rtl/reg_file_mp_if.sv
// Register file port bundle: read, write, and issue signals between the pipeline and reg_file_mp.
// The master side is decode/writeback, and the slave side is the register file itself.
interface reg_file_mp_if #(
  parameter int REG_FILE_BITS = 5,
  parameter int REG_SIZE      = 64,
  parameter int NUM_READ      = 3,
  parameter int NUM_WRITE     = 2
);
  logic [NUM_READ*REG_FILE_BITS-1:0]  read_num;
  logic [NUM_READ*REG_SIZE-1:0]       out_reg;
  logic [NUM_READ-1:0]                out_busy;
  logic [NUM_WRITE-1:0]               we;
  logic [NUM_WRITE*REG_FILE_BITS-1:0] write_num;
  logic [NUM_WRITE*REG_SIZE-1:0]      in_value;
  logic                               issue_valid;
  logic [REG_FILE_BITS-1:0]           issue_num;

  modport master (
    output read_num, we, write_num, in_value, issue_valid, issue_num,
    input  out_reg, out_busy
  );

  modport slave (
    input  read_num, we, write_num, in_value, issue_valid, issue_num,
    output out_reg, out_busy
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-ported RV64 GPR file with combinational reads, prioritized posedge writes,
// optional write-to-read bypass, and a per-register busy scoreboard. x0 always reads zero and is never busy.
module reg_file_mp #(
  parameter int REG_FILE_BITS = 5,
  parameter int REG_FILE_SIZE = 32,
  parameter int REG_SIZE      = 64,
  parameter int NUM_READ      = 3,
  parameter int NUM_WRITE     = 2,
  parameter int BYPASS        = 1
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_mp_if.slave bus
);
  logic [REG_SIZE-1:0]      regs [REG_FILE_SIZE];
  logic [REG_FILE_SIZE-1:0] busy;

  logic [NUM_WRITE-1:0]     wr_en;
  logic [REG_FILE_BITS-1:0] wr_num  [NUM_WRITE];
  logic [REG_SIZE-1:0]      wr_data [NUM_WRITE];
  logic                     issue_ok;

  // Only x1..x(REG_FILE_SIZE-1) hold state; x0 and out-of-range indices are inert.
  function automatic logic in_range(input logic [REG_FILE_BITS-1:0] idx);
    return (idx != '0) && (32'(idx) < 32'(REG_FILE_SIZE));
  endfunction

  for (genvar w = 0; w < NUM_WRITE; w++) begin : g_wr
    assign wr_num[w]  = bus.write_num[w*REG_FILE_BITS +: REG_FILE_BITS];
    assign wr_data[w] = bus.in_value[w*REG_SIZE +: REG_SIZE];
    assign wr_en[w]   = bus.we[w] && in_range(wr_num[w]);
  end

  assign issue_ok = bus.issue_valid && in_range(bus.issue_num);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the whole array is cleared on reset because software expects every GPR to be zero afterwards;
      // this prevents the array from mapping onto a reset-less RAM macro.
      for (int r = 0; r < REG_FILE_SIZE; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      // NOTE: the last non-blocking assignment to the same element wins. The loop runs in ascending port
      // order, so the highest-index port has priority. The issue set comes after the write clear,
      // so a new producer overrides a retiring producer.
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (wr_en[w]) begin
          regs[wr_num[w]] <= wr_data[w];
          busy[wr_num[w]] <= 1'b0;
        end
      end
      if (issue_ok) busy[bus.issue_num] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [REG_FILE_BITS-1:0] idx;
    logic [REG_SIZE-1:0]      data;
    logic                     bsy;

    assign idx = bus.read_num[i*REG_FILE_BITS +: REG_FILE_BITS];

    always_comb begin
      // NOTE: assigning defaults before any branch ensures every path drives data and bsy, so no latch is inferred.
      data = '0;
      bsy  = 1'b0;
      if (in_range(idx)) begin
        data = regs[idx];
        bsy  = busy[idx];
        if (BYPASS != 0) begin
          // A retiring write satisfies the reader in this cycle, so the register no longer reads busy.
          for (int w = 0; w < NUM_WRITE; w++) begin
            if (wr_en[w] && (wr_num[w] == idx)) begin
              data = wr_data[w];
              bsy  = 1'b0;
            end
          end
        end
      end
    end

    assign bus.out_reg[i*REG_SIZE +: REG_SIZE] = data;
    assign bus.out_busy[i]                     = bsy;
  end
endmodule
